// File: rtl/cheri_pkg.sv
// cheri_pkg: shared definitions for the CHERI instruction encoder.
//   enc_op_e   - abstract operation select (31 legal codes, 5'h1f reserved)
//   err_code_e - reject reason reported with err_o
//   Major opcodes, funct3/funct7 and fmt3 imm5 selector constants.
//   fmt2_funct7 / fmt3_imm5 - map an operation to its selector field.
package cheri_pkg;

    typedef enum logic [4:0] {
        OP_CINCADDRIMM     = 5'h00,
        OP_CSETBOUNDSIMM   = 5'h01,
        OP_CSPECIALRW      = 5'h02,
        OP_CSETBOUNDS      = 5'h03,
        OP_CSETBOUNDSEXACT = 5'h04,
        OP_CSEAL           = 5'h05,
        OP_CUNSEAL         = 5'h06,
        OP_CANDPERM        = 5'h07,
        OP_CSETADDR        = 5'h08,
        OP_CINCADDR        = 5'h09,
        OP_CSUB            = 5'h0a,
        OP_CTESTSUBSET     = 5'h0b,
        OP_CSETEQUALEXACT  = 5'h0c,
        OP_GETPERM         = 5'h0d,
        OP_GETTYPE         = 5'h0e,
        OP_GETBASE         = 5'h0f,
        OP_GETLEN          = 5'h10,
        OP_GETTAG          = 5'h11,
        OP_CRRL            = 5'h12,
        OP_CRAM            = 5'h13,
        OP_CMOVE           = 5'h14,
        OP_CCLEARTAG       = 5'h15,
        OP_GETADDR         = 5'h16,
        OP_GETHIGH         = 5'h17,
        OP_GETTOP          = 5'h18,
        OP_AUIPCC          = 5'h19,
        OP_AUICGP          = 5'h1a,
        OP_CJALR           = 5'h1b,
        OP_CJAL            = 5'h1c,
        OP_CLC             = 5'h1d,
        OP_CSC             = 5'h1e,
        OP_RESERVED        = 5'h1f
    } enc_op_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RSVD_OP  = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_MISALIGN = 2'd3
    } err_code_e;

    localparam logic [6:0] OPC_CHERI  = 7'h5b;
    localparam logic [6:0] OPC_AUIPCC = 7'h17;
    localparam logic [6:0] OPC_AUICGP = 7'h7b;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;

    localparam logic [2:0] F3_ZERO         = 3'd0;
    localparam logic [2:0] F3_INCADDRIMM   = 3'd1;
    localparam logic [2:0] F3_SETBOUNDSIMM = 3'd2;
    localparam logic [2:0] F3_CAP          = 3'd3;

    localparam logic [6:0] F7_CSPECIALRW      = 7'h01;
    localparam logic [6:0] F7_CSETBOUNDS      = 7'h08;
    localparam logic [6:0] F7_CSETBOUNDSEXACT = 7'h09;
    localparam logic [6:0] F7_CSEAL           = 7'h0b;
    localparam logic [6:0] F7_CUNSEAL         = 7'h0c;
    localparam logic [6:0] F7_CANDPERM        = 7'h0d;
    localparam logic [6:0] F7_CSETADDR        = 7'h10;
    localparam logic [6:0] F7_CINCADDR        = 7'h11;
    localparam logic [6:0] F7_CSUB            = 7'h14;
    localparam logic [6:0] F7_CTESTSUBSET     = 7'h20;
    localparam logic [6:0] F7_CSETEQUALEXACT  = 7'h21;
    localparam logic [6:0] F7_FMT3            = 7'h7f;

    localparam logic [4:0] IMM5_GETPERM   = 5'h00;
    localparam logic [4:0] IMM5_GETTYPE   = 5'h01;
    localparam logic [4:0] IMM5_GETBASE   = 5'h02;
    localparam logic [4:0] IMM5_GETLEN    = 5'h03;
    localparam logic [4:0] IMM5_GETTAG    = 5'h04;
    localparam logic [4:0] IMM5_CRRL      = 5'h08;
    localparam logic [4:0] IMM5_CRAM      = 5'h09;
    localparam logic [4:0] IMM5_CMOVE     = 5'h0a;
    localparam logic [4:0] IMM5_CCLEARTAG = 5'h0b;
    localparam logic [4:0] IMM5_GETADDR   = 5'h0f;
    localparam logic [4:0] IMM5_GETHIGH   = 5'h17;
    localparam logic [4:0] IMM5_GETTOP    = 5'h18;

    function automatic logic [6:0] fmt2_funct7(input enc_op_e op);
        case (op)
            OP_CSPECIALRW:      return F7_CSPECIALRW;
            OP_CSETBOUNDS:      return F7_CSETBOUNDS;
            OP_CSETBOUNDSEXACT: return F7_CSETBOUNDSEXACT;
            OP_CSEAL:           return F7_CSEAL;
            OP_CUNSEAL:         return F7_CUNSEAL;
            OP_CANDPERM:        return F7_CANDPERM;
            OP_CSETADDR:        return F7_CSETADDR;
            OP_CINCADDR:        return F7_CINCADDR;
            OP_CSUB:            return F7_CSUB;
            OP_CTESTSUBSET:     return F7_CTESTSUBSET;
            OP_CSETEQUALEXACT:  return F7_CSETEQUALEXACT;
            default:            return 7'h00;
        endcase
    endfunction

    function automatic logic [4:0] fmt3_imm5(input enc_op_e op);
        case (op)
            OP_GETPERM:   return IMM5_GETPERM;
            OP_GETTYPE:   return IMM5_GETTYPE;
            OP_GETBASE:   return IMM5_GETBASE;
            OP_GETLEN:    return IMM5_GETLEN;
            OP_GETTAG:    return IMM5_GETTAG;
            OP_CRRL:      return IMM5_CRRL;
            OP_CRAM:      return IMM5_CRAM;
            OP_CMOVE:     return IMM5_CMOVE;
            OP_CCLEARTAG: return IMM5_CCLEARTAG;
            OP_GETADDR:   return IMM5_GETADDR;
            OP_GETHIGH:   return IMM5_GETHIGH;
            OP_GETTOP:    return IMM5_GETTOP;
            default:      return 5'h00;
        endcase
    endfunction

endpackage

// File: rtl/cheri_enc_fifo.sv
// cheri_enc_fifo: generic synchronous valid/ready FIFO with flush.
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            empties the FIFO at the next edge; blocks push and pop
//   push_i/push_data_i write request (ignored when full) and data
//   pop_ready_i        consumer takes the head when valid_o is high
//   valid_o/data_o     head entry; data_o is zero while empty
//   cnt_o, full_o      occupancy and full flag
// Depth must be a power of two so the pointers wrap naturally.
module cheri_enc_fifo #(
    parameter int Depth = 2,
    parameter int Width = 32,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  cnt_o,
    output logic             full_o
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [CntW-1:0]  cnt;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (cnt != '0);
    assign full_o  = (cnt == CntW'(Depth));
    assign cnt_o   = cnt;
    assign data_o  = valid_o ? mem[rptr] : '0;

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = valid_o & pop_ready_i & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; data_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= push_data_i;
    end

endmodule

// File: rtl/cheri_instr_encoder.sv
// cheri_instr_encoder: turns abstract CHERI operation commands into RV32
// CHERI instruction words, buffered in an output FIFO.
//   cmd_valid_i/cmd_ready_o     command handshake (op, rd, rs1, rs2, imm)
//   instr_valid_o/instr_ready_i encoded-word handshake, word on instr_o
//   err_o/err_code_o            one-cycle reject pulse with reason
//   fifo_cnt_o                  FIFO occupancy
//   flush_i                     synchronous FIFO clear
// Optional: define CHERI_ENC_ERRCNT_EN to add err_cnt_o, a saturating count
// of rejected commands (not cleared by flush_i).
module cheri_instr_encoder
    import cheri_pkg::*;
#(
    parameter int FifoDepth = 2,
    parameter int ErrCntW   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [4:0]                 cmd_op_i,
    input  logic [4:0]                 cmd_rd_i,
    input  logic [4:0]                 cmd_rs1_i,
    input  logic [4:0]                 cmd_rs2_i,
    input  logic [31:0]                cmd_imm_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [31:0]                instr_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output logic [$clog2(FifoDepth):0] fifo_cnt_o
`ifdef CHERI_ENC_ERRCNT_EN
    ,
    output logic [ErrCntW-1:0]         err_cnt_o
`endif
);

    enc_op_e            op;
    logic signed [31:0] imm;
    logic               simm12_ok;
    logic               uimm12_ok;
    logic               uimm20_ok;
    logic               jimm_ok;
    logic [31:0]        word;
    err_code_e          code;
    logic               fifo_full;
    logic               accept;
    logic               reject;

    assign op  = enc_op_e'(cmd_op_i);
    assign imm = cmd_imm_i;

    assign simm12_ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
    assign uimm12_ok = (cmd_imm_i[31:12] == 20'd0);
    assign uimm20_ok = (cmd_imm_i[31:20] == 12'd0);
    assign jimm_ok   = (imm >= -32'sd1048576) && (imm <= 32'sd1048574);

    always_comb begin
        word = '0;
        code = ERR_NONE;
        case (op)
            OP_CINCADDRIMM: begin
                word = {imm[11:0], cmd_rs1_i, F3_INCADDRIMM, cmd_rd_i, OPC_CHERI};
                if (!simm12_ok) code = ERR_RANGE;
            end
            OP_CSETBOUNDSIMM: begin
                word = {imm[11:0], cmd_rs1_i, F3_SETBOUNDSIMM, cmd_rd_i, OPC_CHERI};
                if (!uimm12_ok) code = ERR_RANGE;
            end
            OP_CSPECIALRW, OP_CSETBOUNDS, OP_CSETBOUNDSEXACT, OP_CSEAL,
            OP_CUNSEAL, OP_CANDPERM, OP_CSETADDR, OP_CINCADDR, OP_CSUB,
            OP_CTESTSUBSET, OP_CSETEQUALEXACT: begin
                // For CSPECIALRW the rs2 slot carries the SCR index.
                word = {fmt2_funct7(op), cmd_rs2_i, cmd_rs1_i, F3_ZERO, cmd_rd_i, OPC_CHERI};
            end
            OP_GETPERM, OP_GETTYPE, OP_GETBASE, OP_GETLEN, OP_GETTAG,
            OP_CRRL, OP_CRAM, OP_CMOVE, OP_CCLEARTAG, OP_GETADDR,
            OP_GETHIGH, OP_GETTOP: begin
                word = {F7_FMT3, fmt3_imm5(op), cmd_rs1_i, F3_ZERO, cmd_rd_i, OPC_CHERI};
            end
            OP_AUIPCC: begin
                word = {cmd_imm_i[19:0], cmd_rd_i, OPC_AUIPCC};
                if (!uimm20_ok) code = ERR_RANGE;
            end
            OP_AUICGP: begin
                word = {cmd_imm_i[19:0], cmd_rd_i, OPC_AUICGP};
                if (!uimm20_ok) code = ERR_RANGE;
            end
            OP_CJALR: begin
                word = {imm[11:0], cmd_rs1_i, F3_ZERO, cmd_rd_i, OPC_JALR};
                if (!simm12_ok) code = ERR_RANGE;
            end
            OP_CJAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], cmd_rd_i, OPC_JAL};
                // Misalignment outranks range so an odd offset always reports 3.
                if (imm[0])        code = ERR_MISALIGN;
                else if (!jimm_ok) code = ERR_RANGE;
            end
            OP_CLC: begin
                word = {imm[11:0], cmd_rs1_i, F3_CAP, cmd_rd_i, OPC_LOAD};
                if (!simm12_ok) code = ERR_RANGE;
            end
            OP_CSC: begin
                word = {imm[11:5], cmd_rs2_i, cmd_rs1_i, F3_CAP, imm[4:0], OPC_STORE};
                if (!simm12_ok) code = ERR_RANGE;
            end
            default: code = ERR_RSVD_OP;
        endcase
    end

    // Ready depends only on FIFO state and flush, never on instr_ready_i.
    assign cmd_ready_o = ~fifo_full & ~flush_i;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign reject      = accept & (code != ERR_NONE);

    cheri_enc_fifo #(
        .Depth (FifoDepth),
        .Width (32)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (accept & (code == ERR_NONE)),
        .push_data_i (word),
        .pop_ready_i (instr_ready_i),
        .valid_o     (instr_valid_o),
        .data_o      (instr_o),
        .cnt_o       (fifo_cnt_o),
        .full_o      (fifo_full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            err_o      <= reject;
            err_code_o <= reject ? code : ERR_NONE;
        end
    end

`ifdef CHERI_ENC_ERRCNT_EN
    function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     err_cnt_o <= '0;
        else if (reject) err_cnt_o <= sat_inc(err_cnt_o);
    end
`else
    logic unused_err_cnt_cfg;
    assign unused_err_cnt_cfg = (ErrCntW > 0);
`endif

endmodule

// File: tb/tb_cheri_instr_encoder.sv
// tb_cheri_instr_encoder: directed and randomized bench for the CHERI
// instruction encoder, with an ISA-level reference encoder and a queue
// model of the output FIFO.
module tb_cheri_instr_encoder;
    import cheri_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, cmd_valid, cmd_ready, instr_valid, instr_ready, err;
    logic [4:0]  op, rd, rs1, rs2;
    logic [31:0] imm, instr;
    logic [1:0]  err_code, fifo_cnt;
`ifdef CHERI_ENC_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    cheri_instr_encoder #(.FifoDepth(DEPTH), .ErrCntW(8)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (op),
        .cmd_rd_i      (rd),
        .cmd_rs1_i     (rs1),
        .cmd_rs2_i     (rs2),
        .cmd_imm_i     (imm),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .err_o         (err),
        .err_code_o    (err_code),
        .fifo_cnt_o    (fifo_cnt)
`ifdef CHERI_ENC_ERRCNT_EN
        ,
        .err_cnt_o     (err_cnt)
`endif
    );

    // ISA-level reference: returns the reject code (0 = legal) and the word.
    function automatic int ref_enc(input logic [4:0] o, input logic [4:0] d, s1, s2,
                                   input logic [31:0] iv, output logic [31:0] w);
        longint s, acc, lo, hi, f7, mid, f3, opc;
        byte    kind;
        int     code;
        s = longint'($signed(iv));
        kind = "R"; f7 = 0; mid = longint'(s2); f3 = 0; opc = 'h5b;
        lo = -2048; hi = 2047; code = 0; acc = 0;
        case (enc_op_e'(o))
            OP_CINCADDRIMM:     begin kind = "I"; f3 = 1; end
            OP_CSETBOUNDSIMM:   begin kind = "I"; f3 = 2; lo = 0; hi = 4095; end
            OP_CSPECIALRW:      f7 = 'h01;
            OP_CSETBOUNDS:      f7 = 'h08;
            OP_CSETBOUNDSEXACT: f7 = 'h09;
            OP_CSEAL:           f7 = 'h0b;
            OP_CUNSEAL:         f7 = 'h0c;
            OP_CANDPERM:        f7 = 'h0d;
            OP_CSETADDR:        f7 = 'h10;
            OP_CINCADDR:        f7 = 'h11;
            OP_CSUB:            f7 = 'h14;
            OP_CTESTSUBSET:     f7 = 'h20;
            OP_CSETEQUALEXACT:  f7 = 'h21;
            OP_GETPERM:         begin f7 = 'h7f; mid = 'h00; end
            OP_GETTYPE:         begin f7 = 'h7f; mid = 'h01; end
            OP_GETBASE:         begin f7 = 'h7f; mid = 'h02; end
            OP_GETLEN:          begin f7 = 'h7f; mid = 'h03; end
            OP_GETTAG:          begin f7 = 'h7f; mid = 'h04; end
            OP_CRRL:            begin f7 = 'h7f; mid = 'h08; end
            OP_CRAM:            begin f7 = 'h7f; mid = 'h09; end
            OP_CMOVE:           begin f7 = 'h7f; mid = 'h0a; end
            OP_CCLEARTAG:       begin f7 = 'h7f; mid = 'h0b; end
            OP_GETADDR:         begin f7 = 'h7f; mid = 'h0f; end
            OP_GETHIGH:         begin f7 = 'h7f; mid = 'h17; end
            OP_GETTOP:          begin f7 = 'h7f; mid = 'h18; end
            OP_AUIPCC:          begin kind = "U"; opc = 'h17; end
            OP_AUICGP:          begin kind = "U"; opc = 'h7b; end
            OP_CJALR:           begin kind = "I"; opc = 'h67; end
            OP_CJAL:            begin kind = "J"; opc = 'h6f; end
            OP_CLC:             begin kind = "I"; opc = 'h03; f3 = 3; end
            OP_CSC:             begin kind = "S"; opc = 'h23; f3 = 3; end
            default:            begin kind = "X"; code = 1; end
        endcase
        case (kind)
            "R": acc = f7 * (2**25) + mid * (2**20) + longint'(s1) * (2**15) + longint'(d) * 128 + opc;
            "I": begin
                if (s < lo || s > hi) code = 2;
                acc = (s & 'hfff) * (2**20) + longint'(s1) * (2**15) + f3 * 4096 + longint'(d) * 128 + opc;
            end
            "S": begin
                if (s < lo || s > hi) code = 2;
                acc = ((s >>> 5) & 'h7f) * (2**25) + longint'(s2) * (2**20) + longint'(s1) * (2**15)
                      + f3 * 4096 + (s & 31) * 128 + opc;
            end
            "U": begin
                if (longint'(iv) >= 2**20) code = 2;
                acc = (longint'(iv) & 'hfffff) * 4096 + longint'(d) * 128 + opc;
            end
            "J": begin
                if ((s & 1) != 0) code = 3;
                else if (s < -(2**20) || s > 2**20 - 2) code = 2;
                acc = ((s >>> 20) & 1) * (2**31) + ((s >>> 1) & 'h3ff) * (2**21)
                      + ((s >>> 11) & 1) * (2**20) + ((s >>> 12) & 'hff) * 4096 + longint'(d) * 128 + opc;
            end
            default: acc = 0;
        endcase
        w = 32'(acc);
        return code;
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] edges [12] = '{32'd2047, 32'hFFFFF800, 32'd2048, 32'hFFFFF7FF, 32'd4095, 32'd4096,
                                    32'd0, 32'hFFF00000, 32'h000FFFFE, 32'h00100000, 32'h000FFFFF, 32'hFFFFFFFF};
        case ($urandom_range(0, 5))
            0:       return $urandom;
            1:       return edges[$urandom_range(0, 11)];
            2:       return $urandom & 32'h000FFFFF;
            default: return 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endfunction

    task automatic put_cmd(input logic [4:0] o, d, s1, s2, input logic [31:0] iv);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = iv; cmd_valid = 1'b1;
    endtask

    // Drives one always-legal random command (fmt2/fmt3) and returns its word.
    task automatic push_rand(output logic [31:0] w);
        logic [4:0] o, d, s1, s2;
        int         code;
        o = 5'($urandom_range(2, 24)); d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
        code = ref_enc(o, d, s1, s2, 32'd0, w);
        if (code != 0) w = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        put_cmd(o, d, s1, s2, 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; instr_ready = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
        n_cmp++; if (fifo_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
`ifdef CHERI_ENC_ERRCNT_EN
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
`endif
        rst_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_directed();
        logic [4:0]  dop [4] = '{OP_CINCADDRIMM, OP_GETADDR, OP_CSC, OP_CJAL};
        logic [4:0]  drd [4] = '{5'd1, 5'd5, 5'd0, 5'd1};
        logic [4:0]  drs1[4] = '{5'd2, 5'd6, 5'd2, 5'd0};
        logic [4:0]  drs2[4] = '{5'd0, 5'd0, 5'd8, 5'd0};
        logic [31:0] dimm[4] = '{32'h10, 32'h0, 32'h8, 32'd2048};
        logic [31:0] dexp[4] = '{32'h010110DB, 32'hFEF302DB, 32'h00813423, 32'h001000EF};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            put_cmd(dop[i], drd[i], drs1[i], drs2[i], dimm[i]);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (instr_valid !== 1'b1 || instr !== dexp[i]) begin
                n_bad++; $display("FAIL directed_%0d: got v=%b %h want v=1 %h", i, instr_valid, instr, dexp[i]); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL directed_err_%0d: got %b want 0", i, err); end
            instr_ready = 1'b1;
            @(posedge clk); #1;
            instr_ready = 1'b0;
            @(negedge clk);
            n_cmp++; if (fifo_cnt !== 2'd0) begin n_bad++; $display("FAIL directed_pop_%0d: got cnt %0d want 0", i, fifo_cnt); end
        end
    endtask

    task automatic test_errors();
        logic [4:0]  eop [6] = '{OP_CJAL, OP_CINCADDRIMM, OP_RESERVED, OP_CJAL, OP_CSETBOUNDSIMM, OP_AUIPCC};
        logic [31:0] eimm[6] = '{32'd3, 32'd2048, 32'd0, 32'h00200001, 32'hFFFFFFFF, 32'h00100000};
        logic [1:0]  ecode[6] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            put_cmd(eop[i], 5'd1, 5'd2, 5'd3, eimm[i]);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (err !== 1'b1 || err_code !== ecode[i]) begin
                n_bad++; $display("FAIL err_pulse_%0d: got %b/%0d want 1/%0d", i, err, err_code, ecode[i]); end
            n_cmp++; if (fifo_cnt !== 2'd0 || instr_valid !== 1'b0) begin
                n_bad++; $display("FAIL err_nopush_%0d: got cnt %0d valid %b want 0/0", i, fifo_cnt, instr_valid); end
            @(negedge clk);
            n_cmp++; if (err !== 1'b0 || err_code !== 2'd0) begin
                n_bad++; $display("FAIL err_oneshot_%0d: got %b/%0d want 0/0", i, err, err_code); end
        end
    endtask

    task automatic test_full_order();
        logic [31:0] wa, wb;
        instr_ready = 1'b0;
        push_rand(wa);
        push_rand(wb);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b0 || fifo_cnt !== 2'd2) begin
            n_bad++; $display("FAIL full_state: got ready %b cnt %0d want 0/2", cmd_ready, fifo_cnt); end
        n_cmp++; if (instr !== wa) begin n_bad++; $display("FAIL full_head0: got %h want %h", instr, wa); end
        instr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr !== wb || fifo_cnt !== 2'd1) begin
            n_bad++; $display("FAIL full_head1: got %h cnt %0d want %h cnt 1", instr, fifo_cnt, wb); end
        @(posedge clk); #1;
        instr_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_cnt !== 2'd0 || instr_valid !== 1'b0 || instr !== 32'd0) begin
            n_bad++; $display("FAIL full_drain: got cnt %0d v %b %h want 0/0/0", fifo_cnt, instr_valid, instr); end
    endtask

    task automatic test_push_pop();
        logic [31:0] wa, wb;
        push_rand(wa);
        push_rand(wb);
        instr_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_cnt !== 2'd1 || instr !== wb) begin
            n_bad++; $display("FAIL pushpop: got cnt %0d %h want cnt 1 %h", fifo_cnt, instr, wb); end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] wa, wb;
        push_rand(wa);
        push_rand(wb);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_cnt !== 2'd2) begin n_bad++; $display("FAIL flush_pre: got cnt %0d want 2", fifo_cnt); end
        instr_ready = 1'b1;
        put_cmd(OP_CMOVE, 5'd3, 5'd4, 5'd0, 32'd0);
        flush = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", cmd_ready); end
        @(posedge clk); #1;
        flush = 1'b0; cmd_valid = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_cnt !== 2'd0 || instr_valid !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL flush_post: got cnt %0d v %b err %b want 0/0/0", fifo_cnt, instr_valid, err); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] w, exp_w;
        logic        exp_err;
        int          exp_code, code;
        bit          acc;
        exp_err = 1'b0; exp_code = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            flush       = ($urandom_range(0, 19) == 0);
            cmd_valid   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            put_cmd(5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
            cmd_valid   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_w = (q.size() != 0) ? q[0] : 32'd0;
            n_cmp++; if (cmd_ready !== (q.size() < DEPTH && !flush)) begin
                n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, cmd_ready, (q.size() < DEPTH && !flush)); end
            n_cmp++; if (instr_valid !== (q.size() != 0) || instr !== exp_w) begin
                n_bad++; $display("FAIL rnd_head c%0d: got %b %h want %b %h", c, instr_valid, instr, q.size() != 0, exp_w); end
            n_cmp++; if (fifo_cnt !== 2'(q.size())) begin
                n_bad++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, fifo_cnt, q.size()); end
            n_cmp++; if (err !== exp_err || err_code !== 2'(exp_code)) begin
                n_bad++; $display("FAIL rnd_err c%0d: got %b/%0d want %b/%0d", c, err, err_code, exp_err, exp_code); end
            acc  = cmd_valid && (q.size() < DEPTH) && !flush;
            code = ref_enc(op, rd, rs1, rs2, imm, w);
            if (flush) q.delete();
            else begin
                if (q.size() != 0 && instr_ready) void'(q.pop_front());
                if (acc && code == 0) q.push_back(w);
            end
            exp_err  = acc && (code != 0);
            exp_code = exp_err ? code : 0;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; flush = 1'b1; instr_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] wa, wb;
        push_rand(wa);
        push_rand(wb);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #1;
        n_cmp++; if (fifo_cnt !== 2'd2) begin n_bad++; $display("FAIL arst_pre: got cnt %0d want 2", fifo_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (fifo_cnt !== 2'd0 || instr_valid !== 1'b0 || instr !== 32'd0 || err !== 1'b0) begin
            n_bad++; $display("FAIL arst_clear: got cnt %0d v %b %h err %b want 0", fifo_cnt, instr_valid, instr, err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", cmd_ready); end
    endtask

`ifdef CHERI_ENC_ERRCNT_EN
    task automatic test_errcnt();
        @(posedge clk); #1;
        put_cmd(OP_RESERVED, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (10) @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (err_cnt !== 8'd10) begin n_bad++; $display("FAIL errcnt_10: got %0d want 10", err_cnt); end
        cmd_valid = 1'b1;
        repeat (290) @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL errcnt_sat: got %0d want 255", err_cnt); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL errcnt_flush: got %0d want 255", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_full_order();
        test_push_pop();
        test_flush();
        test_random();
        test_async_reset();
`ifdef CHERI_ENC_ERRCNT_EN
        test_errcnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
